// File: rtl/mult_pkg.sv
// Shared definitions for the unsigned multiplier family: FSM encoding,
// default operand width and the product-width rule.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int prod_width(input int width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/seq_array_mult_if.sv
// Operand/result handshake bundle for the sequential multiplier.
interface seq_array_mult_if
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic                         in_valid;
  logic                         in_ready;
  logic [WIDTH-1:0]             a;
  logic [WIDTH-1:0]             b;
  logic                         out_valid;
  logic                         out_ready;
  logic [prod_width(WIDTH)-1:0] product;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, product
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, product
  );

endinterface

// File: rtl/fa.sv
// One-bit full adder cell shared by the multiplier datapaths.
module fa (
  input  logic x,
  input  logic y,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = x ^ y ^ cin;
  assign cout = (x & y) | (cin & (x ^ y));

endmodule

// File: rtl/rca_row.sv
// W-bit ripple-carry adder built by chaining fa cells; purely combinational.
module rca_row #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_bit
    fa u_fa (
      .x   (x[i]),
      .y   (y[i]),
      .cin (w_carry[i]),
      .s   (s[i]),
      .cout(w_carry[i+1])
    );
  end

  assign cout = w_carry[W];

endmodule

// File: rtl/seq_array_mult.sv
// Iterative unsigned multiplier: one partial-product row per clock through a
// single rca_row, with valid/ready handshakes on operands and product.
module seq_array_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic              clk,
  input logic              rst,
  seq_array_mult_if.slave  bus
);

  localparam int PW = prod_width(WIDTH);
  localparam int CW = $clog2(WIDTH) + 1;

  state_e            r_state;
  state_e            w_state_nxt;
  logic [WIDTH-1:0]  r_mcand;
  logic [WIDTH-1:0]  r_mplier;
  logic [PW-1:0]     r_acc;
  logic [PW-1:0]     r_product;
  logic [CW-1:0]     r_cnt;
  logic              r_in_ready;
  logic              r_out_valid;

  logic [WIDTH-1:0]  w_pp;
  logic [WIDTH-1:0]  w_sum;
  logic              w_cout;
  logic [PW-1:0]     w_acc_nxt;
  logic              w_last;
  logic              w_unused;

  assign w_pp = r_mplier[0] ? r_mcand : {WIDTH{1'b0}};

  rca_row #(.W(WIDTH)) u_row (
    .x   (r_acc[PW-1:WIDTH]),
    .y   (w_pp),
    .cin (1'b0),
    .s   (w_sum),
    .cout(w_cout)
  );

  // Carry-out lands in the top bit, so the full 2*WIDTH product is kept.
  assign w_acc_nxt = {w_cout, w_sum, r_acc[WIDTH-1:1]};
  assign w_last    = (r_cnt == CW'(WIDTH - 1));
  assign w_unused  = r_acc[0];

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (bus.in_valid) w_state_nxt = RUN;
        else              w_state_nxt = IDLE;
      end
      RUN: begin
        if (w_last) w_state_nxt = DONE;
        else        w_state_nxt = RUN;
      end
      DONE: begin
        if (bus.out_ready) w_state_nxt = IDLE;
        else               w_state_nxt = DONE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, datapath and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_mcand     <= {WIDTH{1'b0}};
      r_mplier    <= {WIDTH{1'b0}};
      r_acc       <= {PW{1'b0}};
      r_product   <= {PW{1'b0}};
      r_cnt       <= {CW{1'b0}};
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == IDLE);
      r_out_valid <= (w_state_nxt == DONE);
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_mcand  <= bus.a;
            r_mplier <= bus.b;
            r_acc    <= {PW{1'b0}};
            r_cnt    <= {CW{1'b0}};
          end
        end
        RUN: begin
          r_acc    <= w_acc_nxt;
          r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
          r_cnt    <= r_cnt + CW'(1);
          if (w_last) begin
            r_product <= w_acc_nxt;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.product   = r_product;

endmodule

// File: tb/tb_seq_array_mult.sv
// Scoreboard bench for seq_array_mult: expected products are queued at
// acceptance and popped by a monitor on each output handshake.
module tb_seq_array_mult;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  seq_array_mult_if #(.WIDTH(8)) bus8 ();
  seq_array_mult_if #(.WIDTH(4)) bus4 ();

  seq_array_mult #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
  seq_array_mult #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  int          total = 0;
  int          bad   = 0;
  logic [15:0] exp_q[$];
  bit          rdy_random = 1'b0;
  bit          rdy_fixed  = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // out_ready for the 8-bit instance: fixed level or random back-pressure.
  always @(posedge clk) begin
    #2;
    if (rdy_random) bus8.out_ready = ($urandom_range(0, 3) != 0);
    else            bus8.out_ready = rdy_fixed;
  end

  // Monitor: compare on each handshake; flag any result nobody asked for.
  always @(negedge clk) begin
    if (!rst && bus8.out_valid) begin
      if (exp_q.size() == 0) begin
        check("out_valid_without_accept", {31'd0, bus8.out_valid}, 32'd0);
      end else if (bus8.out_ready) begin
        check("product", {16'd0, bus8.product}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // Called in the drive phase (just after a rising edge); returns just after the accepting edge.
  task automatic issue(input logic [7:0] a, input logic [7:0] b);
    bit ok;
    int guard;
    ok = 1'b0;
    guard = 0;
    bus8.a = a;
    bus8.b = b;
    bus8.in_valid = 1'b1;
    while (!ok && guard < 200) begin
      @(negedge clk);
      if (bus8.in_ready) ok = 1'b1;
      else               guard++;
    end
    if (ok) exp_q.push_back(16'(a) * 16'(b));
    else    check("accept_timeout", {31'd0, bus8.in_ready}, 32'd1);
    @(posedge clk);
    #2;
    bus8.in_valid = 1'b0;
    bus8.a = 8'($urandom);
    bus8.b = 8'($urandom);
  endtask

  // Edges up to out_valid, counting the accepting edge as the first.
  task automatic measure_edges(output int edges);
    edges = 1;
    while (edges < 60) begin
      @(negedge clk);
      if (bus8.out_valid) break;
      @(posedge clk);
      edges++;
    end
  endtask

  task automatic run_directed(input logic [7:0] a, input logic [7:0] b);
    int edges;
    issue(a, b);
    measure_edges(edges);
    check("latency_edges", edges, 32'd9);
    @(posedge clk);
    @(negedge clk);
    check("in_ready_after_consume", {31'd0, bus8.in_ready}, 32'd1);
    check("out_valid_after_consume", {31'd0, bus8.out_valid}, 32'd0);
    @(posedge clk);
    #2;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("queue_drained", exp_q.size(), 32'd0);
  endtask

  initial begin
    int edges;
    int gap;
    bus8.in_valid = 1'b0;
    bus8.a = 8'd0;
    bus8.b = 8'd0;
    bus4.in_valid = 1'b0;
    bus4.a = 4'd0;
    bus4.b = 4'd0;
    bus4.out_ready = 1'b1;

    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    check("rst_product", {16'd0, bus8.product}, 32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;

    run_directed(8'hFF, 8'hFF);
    run_directed(8'h00, 8'hA5);
    run_directed(8'h01, 8'hA5);

    // Stall in DONE with a stray operand pulse that must be ignored.
    rdy_fixed = 1'b0;
    issue(8'd13, 8'd11);
    measure_edges(edges);
    check("stall_latency_edges", edges, 32'd9);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #2;
      bus8.in_valid = (i == 1);
      bus8.a = 8'd2;
      bus8.b = 8'd2;
      @(negedge clk);
      check("stall_product", {16'd0, bus8.product}, 32'd143);
      check("stall_out_valid", {31'd0, bus8.out_valid}, 32'd1);
    end
    @(posedge clk);
    #2;
    bus8.in_valid = 1'b0;
    rdy_fixed = 1'b1;
    wait_drain(20);
    repeat (15) @(posedge clk);
    #2;
    run_directed(8'd5, 8'd6);

    // Asynchronous reset in the 4th RUN cycle.
    issue(8'hC3, 8'h5A);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("midrun_rst_out_valid", {31'd0, bus8.out_valid}, 32'd0);
    check("midrun_rst_product", {16'd0, bus8.product}, 32'd0);
    check("midrun_rst_in_ready", {31'd0, bus8.in_ready}, 32'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #2;
    run_directed(8'd3, 8'd7);

    // 4-bit instance.
    bus4.a = 4'hF;
    bus4.b = 4'hF;
    bus4.in_valid = 1'b1;
    @(negedge clk);
    check("w4_in_ready", {31'd0, bus4.in_ready}, 32'd1);
    @(posedge clk);
    #2;
    bus4.in_valid = 1'b0;
    bus4.a = 4'h3;
    edges = 1;
    while (edges < 30) begin
      @(negedge clk);
      if (bus4.out_valid) break;
      @(posedge clk);
      edges++;
    end
    check("w4_latency_edges", edges, 32'd5);
    check("w4_product", {24'd0, bus4.product}, 32'hE1);
    @(posedge clk);
    #2;

    // Random traffic with random gaps and back-pressure.
    rdy_random = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #2;
      end
      issue(8'($urandom), 8'($urandom));
    end
    wait_drain(400);
    rdy_random = 1'b0;
    repeat (5) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
